// File: rtl/gate_unit_arbiter.sv
// Shares one registered (A|B)&C gate unit among NREQ requesters: grants one per cycle and returns its result one cycle later.
// Optional macro GATE_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration; the default build is round-robin.
module gate_unit_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_en,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_req_a,
    input  logic [NREQ-1:0] i_req_b,
    input  logic [NREQ-1:0] i_req_c,
    output logic [NREQ-1:0] o_gnt,
    output logic            o_unit_a,
    output logic            o_unit_b,
    output logic            o_unit_c,
    input  logic            i_unit_o,
    output logic [NREQ-1:0] o_rsp_valid,
    output logic            o_rsp_o,
    output logic            o_busy,
    output logic [15:0]     o_gnt_count
);

    localparam int PW = (NREQ <= 2) ? 1 : ((NREQ <= 4) ? 2 : 3);

    logic            w_grant;
    logic [PW-1:0]   w_winner;
    logic [NREQ-1:0] w_a_terms;
    logic [NREQ-1:0] w_b_terms;
    logic [NREQ-1:0] w_c_terms;

    logic [NREQ-1:0] r_rsp_valid;
    logic            r_busy;
    logic [15:0]     r_gnt_count;

    assign w_grant = i_en && !i_reset && (|i_req);

`ifdef GATE_ARB_FIXED_PRIO_EN
    always_comb begin
        w_winner = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_winner = PW'(k);
            end
        end
    end
`else
    logic [PW-1:0]     r_ptr;
    logic [2*NREQ-2:0] w_req_ext;
    logic [NREQ-1:0]   w_rot;
    logic [PW-1:0]     w_off;
    logic [PW:0]       w_sum;

    // w_req_ext[j] is requester (j+1) mod NREQ, so w_rot lists requests in search order after the pointer.
    for (genvar gi = 0; gi < 2 * NREQ - 1; gi++) begin : g_ext
        assign w_req_ext[gi] = i_req[(gi + 1) % NREQ];
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        assign w_rot[gi] = w_req_ext[(PW+1)'(r_ptr) + (PW+1)'(gi)];
    end

    always_comb begin
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = PW'(k);
            end
        end
        w_sum    = (PW+1)'(r_ptr) + (PW+1)'(w_off) + (PW+1)'(1);
        w_winner = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= PW'(NREQ - 1);
        end else if (w_grant) begin
            r_ptr <= w_winner;
        end
    end
`endif

    // Operand steering is an AND-OR mux keyed by the one-hot grant, so no grant drives zeros.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_steer
        assign o_gnt[gi]     = w_grant && (w_winner == PW'(gi));
        assign w_a_terms[gi] = o_gnt[gi] & i_req_a[gi];
        assign w_b_terms[gi] = o_gnt[gi] & i_req_b[gi];
        assign w_c_terms[gi] = o_gnt[gi] & i_req_c[gi];
    end

    assign o_unit_a = |w_a_terms;
    assign o_unit_b = |w_b_terms;
    assign o_unit_c = |w_c_terms;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= '0;
            r_busy      <= 1'b0;
            r_gnt_count <= '0;
        end else begin
            r_rsp_valid <= o_gnt;
            r_busy      <= w_grant;
            if (w_grant && (r_gnt_count != 16'hFFFF)) begin
                r_gnt_count <= r_gnt_count + 16'd1;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_busy      = r_busy;
    assign o_gnt_count = r_gnt_count;
    assign o_rsp_o     = (|r_rsp_valid) & i_unit_o;

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: per-cycle reference model comparison plus directed literal checks.
module tb_gate_unit_arbiter;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_a = '0;
    logic [NREQ-1:0] req_b = '0;
    logic [NREQ-1:0] req_c = '0;
    logic [NREQ-1:0] gnt;
    logic            unit_a, unit_b, unit_c;
    logic            unit_o;
    logic [NREQ-1:0] rsp_valid;
    logic            rsp_o;
    logic            busy;
    logic [15:0]     gnt_count;

    int n_total = 0;
    int n_pass  = 0;

    gate_unit_arbiter #(.NREQ(NREQ)) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_req(req),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_c(req_c),
        .o_gnt(gnt), .o_unit_a(unit_a), .o_unit_b(unit_b), .o_unit_c(unit_c),
        .i_unit_o(unit_o), .o_rsp_valid(rsp_valid), .o_rsp_o(rsp_o),
        .o_busy(busy), .o_gnt_count(gnt_count)
    );

    always #5 clk = ~clk;

    // The shared gate unit itself: registered (A|B)&C.
    always @(posedge clk) unit_o <= (unit_a | unit_b) & unit_c;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Winner from the rules: walk requesters in priority order, take the first one requesting.
    function automatic int model_winner(input logic [NREQ-1:0] r, input int ptr);
        int order[$];
`ifdef GATE_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) order.push_back(k);
`else
        for (int k = 1; k <= NREQ; k++) order.push_back((ptr + k) % NREQ);
`endif
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    int              m_ptr = NREQ - 1;
    int              m_cnt = 0;
    logic [NREQ-1:0] m_rv  = '0;
    logic            m_ro  = 1'b0;

    always @(negedge clk) begin
        int w;
        logic [NREQ-1:0] eg;
        w  = (en && !rst) ? model_winner(req, m_ptr) : -1;
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("unit_a", 32'(unit_a), (w >= 0) ? 32'(req_a[w]) : 32'd0);
        chk("unit_b", 32'(unit_b), (w >= 0) ? 32'(req_b[w]) : 32'd0);
        chk("unit_c", 32'(unit_c), (w >= 0) ? 32'(req_c[w]) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_o", 32'(rsp_o), 32'(m_ro));
        chk("busy", 32'(busy), 32'(m_rv != 0));
        chk("gnt_count", 32'(gnt_count), 32'(m_cnt));
        if (rst) begin
            m_ptr = NREQ - 1; m_cnt = 0; m_rv = '0; m_ro = 1'b0;
        end else if (w >= 0) begin
            m_ptr = w;
            if (m_cnt < 65535) m_cnt++;
            m_rv = eg;
            m_ro = (req_a[w] | req_b[w]) & req_c[w];
        end else begin
            m_rv = '0; m_ro = 1'b0;
        end
    end

    // Inputs change just after the rising edge; returns at the following falling edge.
    task automatic drive(input logic r, input logic e, input logic [NREQ-1:0] q,
                         input logic [NREQ-1:0] a, input logic [NREQ-1:0] b, input logic [NREQ-1:0] c);
        @(posedge clk);
        #1;
        rst = r; en = e; req = q; req_a = a; req_b = b; req_c = c;
        @(negedge clk);
    endtask

    logic [NREQ-1:0] rot_exp [5];

    initial begin
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        drive(1, 0, 4'b0000, 0, 0, 0);
        drive(1, 1, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_unit_a", 32'(unit_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'b0000, 0, 0, 0);
            chk("idle_gnt", 32'(gnt), 32'd0);
            chk("idle_rv", 32'(rsp_valid), 32'd0);
            chk("idle_cnt", 32'(gnt_count), 32'd0);
            chk("idle_units", 32'({unit_a, unit_b, unit_c}), 32'd0);
        end

`ifdef GATE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'b1010, 4'b1111, 4'b0000, 4'b1111);
            chk("fixed_gnt", 32'(gnt), 32'b0010);
        end
`else
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'b1111, 4'b1111, 4'b0000, 4'b1111);
            chk("rr_gnt", 32'(gnt), 32'(rot_exp[i]));
            if (i > 0) begin
                chk("rr_rv", 32'(rsp_valid), 32'(rot_exp[i-1]));
                chk("rr_rsp_o", 32'(rsp_o), 32'd1);
            end
        end
`endif
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk("rr_cnt5", 32'(gnt_count), 32'd5);
        chk("rr_last_rsp_o", 32'(rsp_o), 32'd1);

        drive(0, 1, 4'b0100, 4'b0000, 4'b0100, 4'b0000);
        chk("steer_gnt", 32'(gnt), 32'b0100);
        chk("steer_unit_b", 32'(unit_b), 32'd1);
        drive(0, 1, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        chk("steer_rv", 32'(rsp_valid), 32'b0100);
        chk("steer_rsp_o0", 32'(rsp_o), 32'd0);
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk("steer_rsp_o1", 32'(rsp_o), 32'd1);

        drive(1, 0, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 4'b0011, 4'b0011, 0, 4'b0011);
            chk("en0_gnt", 32'(gnt), 32'd0);
        end
        drive(0, 1, 4'b0011, 4'b0011, 0, 4'b0011);
        chk("en1_gnt", 32'(gnt), 32'b0001);

        drive(0, 1, 4'b0100, 4'b0100, 0, 4'b0100);
        chk("mid_gnt", 32'(gnt), 32'b0100);
        drive(1, 1, 4'b0100, 4'b0100, 0, 4'b0100);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        drive(0, 1, 4'b1111, 0, 0, 0);
        chk("mid_rv", 32'(rsp_valid), 32'd0);
        chk("mid_rsp_o", 32'(rsp_o), 32'd0);
        chk("mid_cnt", 32'(gnt_count), 32'd0);
        chk("mid_restart", 32'(gnt), 32'b0001);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  NREQ'($urandom), NREQ'($urandom), NREQ'($urandom), NREQ'($urandom));
        end

        drive(1, 0, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 65535; i++) drive(0, 1, 4'b0001, 4'b0001, 0, 4'b0001);
        chk("sat_fffe", 32'(gnt_count), 32'hFFFE);
        for (int i = 0; i < 3; i++) drive(0, 1, 4'b0001, 4'b0001, 0, 4'b0001);
        drive(0, 1, 4'b0000, 0, 0, 0);
        chk("sat_ffff", 32'(gnt_count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gate_unit_arbiter.md
# gate_unit_arbiter

Round-robin arbiter that shares one registered gate unit, computing O = (A | B) & C one cycle after sampling, among NREQ requesters. Each cycle it grants at most one requester and steers that requester's operands onto the unit's A/B/C inputs. One cycle later it returns the unit's output to the same requester with a one-hot valid. It sits between the requester logic and the single gate-unit instance and is the only driver of that unit's operand inputs.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- en  in  1  grant enable; 0 = no new grants, in-flight response still returned
- req  in  NREQ  bit i = requester i has an operation pending
- req_a, req_b, req_c  in  NREQ each  bit i = A/B/C operand of requester i
- gnt  out  NREQ  combinational; one-hot or zero; transfer when req[i] & gnt[i]
- unit_a, unit_b, unit_c  out  1 each  operands driven to the gate unit; operands of the granted requester, else 0
- unit_o  in  1  registered result from the gate unit
- rsp_valid  out  NREQ  registered; one-hot or zero; result for requester i this cycle
- rsp_o  out  1  equals unit_o when any rsp_valid bit is 1, else 0
- busy  out  1  registered; 1 when a response is in flight (OR of rsp_valid)
- gnt_count  out  16  registered count of grants issued; saturates at 16'hFFFF

## Operation
- Reset values: rsp_valid=0, busy=0, gnt_count=0, last-grant pointer=NREQ-1. While reset=1, gnt=0 and unit_a/b/c=0 combinationally.
- Arbitration is evaluated every cycle with en=1, reset=0 and req≠0.
  - Winner is the first set req bit, searching upward from (pointer+1) mod NREQ and wrapping past NREQ-1 to 0.
  - gnt = one-hot winner.
  - unit_a/b/c = req_a/b/c[winner].
- On a grant edge:
  - pointer ← winner.
  - rsp_valid ← one-hot winner.
  - gnt_count ← gnt_count+1, unless already 16'hFFFF.
- On a cycle with no grant (en=0, req=0, or reset): pointer and gnt_count hold, and rsp_valid ← 0.
- A requester keeps req high until it sees gnt for that cycle. A requester may issue back-to-back operations by holding req; round-robin still rotates whenever others are requesting.
- Single requester: a lone requester is granted every cycle with en=1.
- Reset mid-operation: an in-flight response is discarded. rsp_valid is 0 the cycle after reset is sampled, even though unit_o may still carry the old result. Reset takes priority over a simultaneous grant.
- No backpressure on responses: rsp_valid is a one-cycle pulse and the requester must capture rsp_o in that cycle.

## Timing
- Grant latency is 0 cycles: gnt follows req/en/pointer combinationally in the same cycle.
- Result latency is 1 cycle. Grant in cycle t gives rsp_valid[winner]=1 in cycle t+1, with rsp_o = unit_o = (a|b)&c of the operands sampled at the end of cycle t.
- Throughput: one operation per cycle, fully pipelined; rsp_valid for grant t and gnt for grant t+1 may coincide.
- Dropping en in cycle t blocks the grant in t only; a response from t-1 is still delivered in t.

## Configuration
- GATE_ARB_FIXED_PRIO_EN
  - Defined: fixed priority. The lowest-index set req bit wins, and the pointer register is not implemented.
  - Undefined (default): round-robin as described above.
  - All ports, latency and gnt_count behaviour are identical in both modes.

## Test plan
- Reset, then req=4'b0000 for 3 cycles: gnt=0, rsp_valid=0, gnt_count=0, unit_a/b/c=0.
- Round-robin rotation: req=4'b1111 held for 5 cycles with all operands a=1, b=0, c=1.
  - gnt sequence is 0001, 0010, 0100, 1000, 0001.
  - rsp_valid follows one cycle later with rsp_o=1.
  - gnt_count=5.
- Operand steering: req=4'b0100 with req_a=4'b0000, req_b=4'b0100, req_c=4'b0000.
  - gnt=0100 and unit_b=1.
  - Next cycle rsp_valid=0100, rsp_o=0.
  - Repeat with req_c=4'b0100: rsp_o=1.
- en gating: req=4'b0011, en=0 for 2 cycles, then en=1.
  - No gnt while en=0.
  - First grant after en=1 goes to requester 0, since the pointer is unchanged from reset.
- Reset mid-flight: grant requester 2, then assert reset in the following cycle.
  - rsp_valid=0 in the cycle after reset is sampled, gnt_count=0, and the pointer restarts so requester 0 wins next.
- Saturation: preload gnt_count to 16'hFFFE via a long run with req=4'b0001, then grant 3 more times.
  - gnt_count stops at 16'hFFFF.
  - Under GATE_ARB_FIXED_PRIO_EN with req=4'b1010: gnt=0010 on every cycle.
